rx_chan_align: RTL and testbench

Receive-path sample-set aligner sitting directly upstream of the USB receive FIFO writer. Collects the I/Q outputs of up to four DDC channels, each with its own decimation strobe, into one coherent sample set. Presents the set as eight 16-bit words `ch_0`..`ch_7` with a single one-cycle `rxstrobe`. Detects and counts strobe misalignment and stalled channels, so the FIFO writer never packs a torn sample set.

---
 rtl/rx_chan_align.sv | 142 ++++++++++++++
 tb/tb_rx_chan_align.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_chan_align.sv
// rx_chan_align: gathers per-DDC I/Q samples into coherent sets for the RX FIFO writer
//
// Ports:
//   rxclk, reset          clock and synchronous active-high reset
//   channels              words per set (2/4/6/8); active DDCs = min(channels>>1, 4)
//   ddc_strobe            per-DDC sample valid, bit k qualifies ddck_i/ddck_q
//   ddc0_i..ddc3_q        DDC outputs
//   clear_err             clears align_err and drop_count
//   rxstrobe              one-cycle pulse, ch_* hold a new complete set
//   ch_0..ch_7            ch_(2k) = DDC k I, ch_(2k+1) = DDC k Q
//   align_err             sticky torn/timed-out flag
//   drop_count            saturating count of discarded partial sets
module rx_chan_align #(
    parameter int TIMEOUT = 1024
) (
    input  logic        rxclk,
    input  logic        reset,
    input  logic [3:0]  channels,
    input  logic [3:0]  ddc_strobe,
    input  logic [15:0] ddc0_i,
    input  logic [15:0] ddc0_q,
    input  logic [15:0] ddc1_i,
    input  logic [15:0] ddc1_q,
    input  logic [15:0] ddc2_i,
    input  logic [15:0] ddc2_q,
    input  logic [15:0] ddc3_i,
    input  logic [15:0] ddc3_q,
    input  logic        clear_err,
    output logic        rxstrobe,
    output logic [15:0] ch_0,
    output logic [15:0] ch_1,
    output logic [15:0] ch_2,
    output logic [15:0] ch_3,
    output logic [15:0] ch_4,
    output logic [15:0] ch_5,
    output logic [15:0] ch_6,
    output logic [15:0] ch_7,
    output logic        align_err,
    output logic [15:0] drop_count
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t           state_q, state_d;
    logic [3:0]       got_q, got_d, chan_q, mask, s;
    logic [TW-1:0]    timer_q, timer_d;
    logic [3:0][31:0] din, hold_q, hold_d, ch_q, ch_d;
    logic             stb_q, stb_d, err_q, err_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             drop, comp, chg, torn, tmo, collect;
    logic [2:0]       n;

    assign n       = channels[3:1];
    assign mask    = n[2] ? 4'hF : (4'h1 << n[1:0]) - 4'h1;
    assign s       = ddc_strobe & mask;
    assign din     = {ddc3_i, ddc3_q, ddc2_i, ddc2_q, ddc1_i, ddc1_q, ddc0_i, ddc0_q};
    assign collect = state_q == COLLECT;
    assign chg     = collect && channels != chan_q;
    assign torn    = collect && (s & got_q) != 4'h0;
    assign comp    = mask != 4'h0 && ((got_q | s) & mask) == mask;
    assign tmo     = collect && timer_q == TW'(TIMEOUT - 1);

    // hold_d is also the newest sample per DDC, which is what an emission carries
    for (genvar k = 0; k < 4; k++) begin : g_hold
        assign hold_d[k] = s[k] ? din[k] : hold_q[k];
    end

    // a channel change outranks everything, then a torn set outranks completion
    always_comb begin
        state_d = state_q;
        got_d   = got_q;
        timer_d = '0;
        ch_d    = ch_q;
        stb_d   = 1'b0;
        drop    = 1'b0;
        if (chg) begin
            drop    = 1'b1;
            got_d   = 4'h0;
            state_d = IDLE;
        end else if (torn) begin
            drop  = 1'b1;
            got_d = s;
        end else if (comp) begin
            stb_d   = 1'b1;
            got_d   = 4'h0;
            state_d = IDLE;
            for (int k = 0; k < 4; k++) ch_d[k] = mask[k] ? hold_d[k] : 32'h0;
        end else if (tmo) begin
            drop    = 1'b1;
            got_d   = 4'h0;
            state_d = IDLE;
        end else if (collect) begin
            got_d   = got_q | s;
            timer_d = timer_q + 1'b1;
        end else if (s != 4'h0) begin
            got_d   = s;
            state_d = COLLECT;
        end
    end

    // a drop in the same cycle as clear_err wins and restarts the count at one
    assign err_d = drop | (err_q & ~clear_err);
    assign cnt_d = drop ? (clear_err ? 16'h1 : cnt_q + {15'h0, cnt_q != 16'hFFFF})
                        : (clear_err ? 16'h0 : cnt_q);

    always_ff @(posedge rxclk) begin
        if (reset) begin
            state_q <= IDLE;
            got_q   <= 4'h0;
            chan_q  <= 4'h0;
            timer_q <= '0;
            hold_q  <= '0;
            ch_q    <= '0;
            stb_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 16'h0;
        end else begin
            state_q <= state_d;
            got_q   <= got_d;
            chan_q  <= channels;
            timer_q <= timer_d;
            hold_q  <= hold_d;
            ch_q    <= ch_d;
            stb_q   <= stb_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rxstrobe   = stb_q;
    assign align_err  = err_q;
    assign drop_count = cnt_q;
    assign ch_0       = ch_q[0][31:16];
    assign ch_1       = ch_q[0][15:0];
    assign ch_2       = ch_q[1][31:16];
    assign ch_3       = ch_q[1][15:0];
    assign ch_4       = ch_q[2][31:16];
    assign ch_5       = ch_q[2][15:0];
    assign ch_6       = ch_q[3][31:16];
    assign ch_7       = ch_q[3][15:0];
endmodule

// File: tb/tb_rx_chan_align.sv
// tb_rx_chan_align: randomized and directed check of rx_chan_align against a set-level model
module tb_rx_chan_align;
    localparam int TO = 16;

    logic        rxclk = 1'b0;
    logic        reset = 1'b1;
    logic        clear_err = 1'b0;
    logic [3:0]  channels = 4'h0;
    logic [3:0]  ddc_strobe = 4'h0;
    logic [15:0] di[4];
    logic [15:0] dq[4];
    logic [15:0] ch[8];
    logic        rxstrobe, align_err;
    logic [15:0] drop_count;
    int          total = 0;
    int          bad = 0;

    bit          busy;
    bit          have[4];
    int          age;
    logic [15:0] hi[4], hq[4];
    logic [3:0]  prev_ch;
    logic        m_stb, m_err;
    logic [15:0] m_cnt;
    logic [15:0] m_ch[8];

    rx_chan_align #(.TIMEOUT(TO)) dut (
        .rxclk(rxclk), .reset(reset), .channels(channels), .ddc_strobe(ddc_strobe),
        .ddc0_i(di[0]), .ddc0_q(dq[0]), .ddc1_i(di[1]), .ddc1_q(dq[1]),
        .ddc2_i(di[2]), .ddc2_q(dq[2]), .ddc3_i(di[3]), .ddc3_q(dq[3]),
        .clear_err(clear_err), .rxstrobe(rxstrobe),
        .ch_0(ch[0]), .ch_1(ch[1]), .ch_2(ch[2]), .ch_3(ch[3]),
        .ch_4(ch[4]), .ch_5(ch[5]), .ch_6(ch[6]), .ch_7(ch[7]),
        .align_err(align_err), .drop_count(drop_count)
    );

    always #5 rxclk = ~rxclk;

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] actual=%h expected=%h at %0t", nm, idx, act, exp, $time);
        end
    endtask

    task tick;
        @(posedge rxclk);
        #1;
    endtask

    // set-level model: stash samples, emit when every active DDC has one
    always @(posedge rxclk) begin : model
        int n;
        bit drop, emit, rep, full, any;
        if (reset) begin
            busy = 0; age = 0; prev_ch = 4'h0;
            m_stb = 1'b0; m_err = 1'b0; m_cnt = 16'h0;
            for (int k = 0; k < 4; k++) begin
                have[k] = 0; hi[k] = 16'h0; hq[k] = 16'h0;
            end
            for (int k = 0; k < 8; k++) m_ch[k] = 16'h0;
        end else begin
            n = int'(channels >> 1);
            if (n > 4) n = 4;
            drop = 0;
            emit = 0;
            if (busy && channels != prev_ch) begin
                drop = 1;
                busy = 0;
                for (int k = 0; k < 4; k++) have[k] = 0;
            end else begin
                rep = 0;
                for (int k = 0; k < n; k++) if (ddc_strobe[k] && have[k]) rep = 1;
                for (int k = 0; k < n; k++) if (ddc_strobe[k]) begin
                    hi[k] = di[k];
                    hq[k] = dq[k];
                end
                if (rep) begin
                    drop = 1;
                    age = 0;
                    for (int k = 0; k < 4; k++) have[k] = (k < n) && ddc_strobe[k];
                end else begin
                    for (int k = 0; k < n; k++) if (ddc_strobe[k]) have[k] = 1;
                    full = n > 0;
                    any = 0;
                    for (int k = 0; k < n; k++) begin
                        full = full && have[k];
                        any = any || have[k];
                    end
                    if (full) begin
                        emit = 1;
                        busy = 0;
                        age = 0;
                        for (int k = 0; k < 4; k++) begin
                            m_ch[2*k]   = (k < n) ? hi[k] : 16'h0;
                            m_ch[2*k+1] = (k < n) ? hq[k] : 16'h0;
                            have[k] = 0;
                        end
                    end else if (busy && age == TO - 1) begin
                        drop = 1;
                        busy = 0;
                        age = 0;
                        for (int k = 0; k < 4; k++) have[k] = 0;
                    end else if (busy) begin
                        age++;
                    end else if (any) begin
                        busy = 1;
                        age = 0;
                    end
                end
            end
            m_stb = emit;
            if (drop) begin
                m_err = 1'b1;
                m_cnt = clear_err ? 16'h1 : (m_cnt == 16'hFFFF ? m_cnt : m_cnt + 16'd1);
            end else if (clear_err) begin
                m_err = 1'b0;
                m_cnt = 16'h0;
            end
            prev_ch = channels;
        end
    end

    always @(negedge rxclk) begin
        chk("rxstrobe", 0, 16'(rxstrobe), 16'(m_stb));
        chk("align_err", 0, 16'(align_err), 16'(m_err));
        chk("drop_count", 0, drop_count, m_cnt);
        for (int k = 0; k < 8; k++) chk("ch", k, ch[k], m_ch[k]);
    end

    initial begin
        logic [15:0] v;
        int pulses;
        for (int k = 0; k < 4; k++) begin
            di[k] = 16'h0;
            dq[k] = 16'h0;
        end
        repeat (3) tick;
        chk("rst_stb", 0, 16'(rxstrobe), 16'h0);
        chk("rst_err", 0, 16'(align_err), 16'h0);
        chk("rst_drop", 0, drop_count, 16'h0);
        chk("rst_ch", 0, ch[0], 16'h0);
        reset = 1'b0;
        channels = 4'd4;
        tick;

        v = 16'h0010;
        for (int r = 0; r < 5; r++) begin
            di[0] = v; dq[0] = v + 16'd1; di[1] = v + 16'd2; dq[1] = v + 16'd3;
            di[2] = 16'hDEAD; dq[3] = 16'hBEEF;
            ddc_strobe = (r == 2) ? 4'hF : 4'h3;
            tick;
            chk("t1_stb", r, 16'(rxstrobe), 16'h1);
            if (r == 0) begin
                chk("t1_ch", 0, ch[0], 16'h0010);
                chk("t1_ch", 3, ch[3], 16'h0013);
            end
            if (r == 2) chk("t1_ch", 4, ch[4], 16'h0000);
            ddc_strobe = 4'h0;
            v = v + 16'd4;
            repeat (7) tick;
        end
        chk("t1_drop", 0, drop_count, 16'h0);

        channels = 4'd8;
        tick;
        for (int k = 0; k < 4; k++) begin
            ddc_strobe = 4'(1 << k);
            di[k] = 16'(16'h1000 + k);
            dq[k] = 16'(16'h2000 + k);
            tick;
            if (k < 3) chk("t2_early", k, 16'(rxstrobe), 16'h0);
        end
        chk("t2_stb", 0, 16'(rxstrobe), 16'h1);
        chk("t2_ch", 0, ch[0], 16'h1000);
        chk("t2_ch", 5, ch[5], 16'h2002);
        chk("t2_ch", 6, ch[6], 16'h1003);
        chk("t2_err", 0, 16'(align_err), 16'h0);
        ddc_strobe = 4'h0;
        tick;

        channels = 4'd4;
        tick;
        ddc_strobe = 4'h1;
        di[0] = 16'hA001;
        tick;
        di[0] = 16'hA002;
        tick;
        chk("t3_err", 0, 16'(align_err), 16'h1);
        chk("t3_drop", 0, drop_count, 16'h1);
        ddc_strobe = 4'h2;
        di[1] = 16'hB001;
        tick;
        chk("t3_stb", 0, 16'(rxstrobe), 16'h1);
        chk("t3_ch", 0, ch[0], 16'hA002);
        chk("t3_ch", 2, ch[2], 16'hB001);
        ddc_strobe = 4'h0;
        tick;

        channels = 4'd2;
        clear_err = 1'b1;
        tick;
        clear_err = 1'b0;
        chk("t4_clr", 0, drop_count, 16'h0);
        channels = 4'd4;
        tick;
        ddc_strobe = 4'h1;
        di[0] = 16'hC001;
        tick;
        ddc_strobe = 4'h0;
        repeat (TO - 1) tick;
        chk("t4_wait", 0, drop_count, 16'h0);
        tick;
        chk("t4_drop", 0, drop_count, 16'h1);
        chk("t4_err", 0, 16'(align_err), 16'h1);
        chk("t4_stb", 0, 16'(rxstrobe), 16'h0);

        channels = 4'd8;
        tick;
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            ddc_strobe = 4'hF;
            for (int k = 0; k < 4; k++) begin
                di[k] = 16'($urandom);
                dq[k] = 16'($urandom);
            end
            tick;
            if (rxstrobe) pulses++;
        end
        ddc_strobe = 4'h0;
        tick;
        chk("t5_pulses", 0, 16'(pulses), 16'd100);

        channels = 4'd4;
        tick;
        ddc_strobe = 4'h1;
        for (int i = 0; i < 65700; i++) begin
            di[0] = 16'(i);
            clear_err = (i == 100);
            tick;
        end
        clear_err = 1'b0;
        chk("sat_drop", 0, drop_count, 16'hFFFF);
        chk("sat_err", 0, 16'(align_err), 16'h1);
        ddc_strobe = 4'h0;
        clear_err = 1'b1;
        tick;
        clear_err = 1'b0;
        chk("sat_clr", 0, drop_count, 16'h0);
        chk("sat_clr_err", 0, 16'(align_err), 16'h0);
        repeat (TO + 4) tick;
        chk("sat_tmo", 0, drop_count, 16'h1);

        ddc_strobe = 4'h3;
        di[0] = 16'h5A5A;
        tick;
        chk("rc_ch", 0, ch[0], 16'h5A5A);
        ddc_strobe = 4'h1;
        tick;
        ddc_strobe = 4'h0;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("rc_ch", 0, ch[0], 16'h0);
        chk("rc_drop", 0, drop_count, 16'h0);
        chk("rc_err", 0, 16'(align_err), 16'h0);
        ddc_strobe = 4'h2;
        tick;
        chk("rc_stb", 0, 16'(rxstrobe), 16'h0);
        ddc_strobe = 4'h0;
        tick;

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) channels = 4'($urandom_range(0, 15));
            ddc_strobe = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom) & 4'($urandom);
            for (int k = 0; k < 4; k++) begin
                di[k] = 16'($urandom);
                dq[k] = 16'($urandom);
            end
            clear_err = ($urandom_range(0, 39) == 0);
            reset = ($urandom_range(0, 499) == 0);
            tick;
        end
        reset = 1'b0;
        clear_err = 1'b0;
        ddc_strobe = 4'h0;
        repeat (3) tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
